// File: rtl/spi_slave_burst.sv
// rtl/spi_slave_burst.sv - SPI slave command decoder with single and burst access to an external synchronous RAM
module spi_slave_burst #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int CMD_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cmd_err
);

    localparam int F     = CMD_WIDTH + DATA_WIDTH;
    localparam int CNT_W = $clog2(F + 1);

    if (ADDR_WIDTH > DATA_WIDTH) begin : g_bad_addr_width
        $error("spi_slave_burst: ADDR_WIDTH must not exceed DATA_WIDTH");
    end
    if (CMD_WIDTH != 3) begin : g_bad_cmd_width
        $error("spi_slave_burst: CMD_WIDTH must be 3");
    end
    if (DATA_WIDTH < 2) begin : g_bad_data_width
        $error("spi_slave_burst: DATA_WIDTH must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_BURST,
        RD_WAIT,
        RD_SHIFT,
        DONE
    } state_t;

    localparam logic [2:0] OP_WR_ADDR  = 3'b000;
    localparam logic [2:0] OP_WR_DATA  = 3'b001;
    localparam logic [2:0] OP_WR_BURST = 3'b010;
    localparam logic [2:0] OP_RD_BURST = 3'b011;
    localparam logic [2:0] OP_RD_ADDR  = 3'b110;
    localparam logic [2:0] OP_RD_DATA  = 3'b111;

    state_t                state;
    state_t                state_nx;
    logic [CNT_W-1:0]      bit_cnt;
    logic [F-2:0]          rx_shift;
    logic [F-1:0]          frame;
    logic [2:0]            cmd;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] pf_data;
    logic [DATA_WIDTH-1:0] load_data;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_burst;
    logic                  rd_pending;
    logic                  frame_end;
    logic                  word_end;
    logic                  load_word;

    // frame includes the bit sampled on the current edge, so decode happens on that same edge
    assign frame     = {rx_shift, MOSI};
    assign cmd       = frame[F-1 -: 3];
    assign word      = frame[DATA_WIDTH-1:0];
    // rd_pending marks mem_rdata as live this cycle; otherwise use the captured prefetch
    assign load_data = rd_pending ? mem_rdata : pf_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        frame_end = 1'b0;
        word_end  = 1'b0;
        load_word = 1'b0;
        if (SS_n) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: state_nx = CMD;
                CMD: begin
                    if (bit_cnt == CNT_W'(F - 1)) begin
                        frame_end = 1'b1;
                        case (cmd)
                            OP_WR_BURST:            state_nx = WR_BURST;
                            OP_RD_DATA, OP_RD_BURST: state_nx = RD_WAIT;
                            default:                state_nx = DONE;
                        endcase
                    end
                end
                WR_BURST: word_end = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
                RD_WAIT: begin
                    if (bit_cnt == CNT_W'(1)) begin
                        load_word = 1'b1;
                        state_nx  = RD_SHIFT;
                    end
                end
                RD_SHIFT: begin
                    if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
                        if (rd_burst) begin
                            load_word = 1'b1;
                        end else begin
                            state_nx = DONE;
                        end
                    end
                end
                DONE:    state_nx = DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            pf_data    <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_burst   <= 1'b0;
            rd_pending <= 1'b0;
            MISO       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            cmd_err    <= 1'b0;
            rd_pending <= mem_re;
            if (SS_n) begin
                bit_cnt    <= '0;
                rd_burst   <= 1'b0;
                rd_pending <= 1'b0;
                MISO       <= 1'b0;
            end else begin
                rx_shift <= frame[F-2:0];
                if (rd_pending && !load_word) begin
                    pf_data <= mem_rdata;
                end
                case (state)
                    IDLE: bit_cnt <= '0;
                    CMD: begin
                        if (frame_end) begin
                            bit_cnt <= '0;
                            case (cmd)
                                OP_WR_ADDR: wr_addr <= word[ADDR_WIDTH-1:0];
                                OP_WR_DATA, OP_WR_BURST: begin
                                    mem_we    <= 1'b1;
                                    mem_addr  <= wr_addr;
                                    mem_wdata <= word;
                                    if (cmd == OP_WR_BURST) begin
                                        wr_addr <= wr_addr + 1'b1;
                                    end
                                end
                                OP_RD_ADDR: rd_addr <= word[ADDR_WIDTH-1:0];
                                OP_RD_DATA, OP_RD_BURST: begin
                                    mem_re   <= 1'b1;
                                    mem_addr <= rd_addr;
                                    rd_burst <= (cmd == OP_RD_BURST);
                                end
                                default: cmd_err <= 1'b1;
                            endcase
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    WR_BURST: begin
                        if (word_end) begin
                            bit_cnt   <= '0;
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_addr;
                            mem_wdata <= word;
                            wr_addr   <= wr_addr + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    RD_WAIT: bit_cnt <= bit_cnt + 1'b1;
                    RD_SHIFT: begin
                        if (bit_cnt == CNT_W'(DATA_WIDTH)) begin
                            MISO <= 1'b0;
                        end else begin
                            MISO     <= tx_shift[DATA_WIDTH-1];
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                            bit_cnt  <= bit_cnt + 1'b1;
                        end
                    end
                    default: MISO <= 1'b0;
                endcase
                // MSB goes straight to MISO; the shifter holds the remaining bits
                if (load_word) begin
                    MISO     <= load_data[DATA_WIDTH-1];
                    tx_shift <= {load_data[DATA_WIDTH-2:0], 1'b0};
                    bit_cnt  <= CNT_W'(1);
                    if (rd_burst) begin
                        rd_addr  <= rd_addr + 1'b1;
                        mem_addr <= rd_addr + 1'b1;
                        mem_re   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_burst.sv
// tb/tb_spi_slave_burst.sv - scoreboard bench for spi_slave_burst
module tb_spi_slave_burst;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int F  = 3 + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic          cmd_err;

    logic [DW-1:0]    mem     [0:255];
    logic [DW-1:0]    ref_mem [0:255];
    logic [DW-1:0]    bw      [0:3];
    logic [AW+DW-1:0] exp_wr  [$];
    logic [DW-1:0]    exp_rd  [$];
    logic [AW-1:0]    wr_addr_m;
    logic [AW-1:0]    rd_addr_m;
    logic             pl_en = 1'b0;
    logic [AW-1:0]    pl_addr;
    logic [DW-1:0]    pl_data;
    int               n_checks = 0;
    int               n_errors = 0;

    always #5 clk = ~clk;

    spi_slave_burst #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CMD_WIDTH (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_rdata(mem_rdata),
        .cmd_err  (cmd_err)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            chk("we_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) chk("mem_write", 32'({mem_addr, mem_wdata}), 32'(exp_wr.pop_front()));
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // drives one SS_n-low window; n-th negedge drives bit n and observes the state after edge n-1
    task automatic xfer(input logic [2:0] cmd, input logic [DW-1:0] payload, input int n_words,
                        input int stop_at, input int rst_at);
        logic [F-1:0]  fr;
        logic [DW-1:0] w;
        logic [DW-1:0] got;
        bit            is_rd;
        int            total;
        int            j;
        is_rd = (cmd == 3'b111) || (cmd == 3'b011);
        if (is_rd) total = F + 1 + n_words * DW + ((cmd == 3'b111) ? 2 : 0);
        else if (cmd == 3'b010) total = F + (n_words - 1) * DW;
        else total = F;
        if (stop_at >= 0) total = stop_at;
        got = '0;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int n = 1; n <= total + 1; n++) begin
            @(negedge clk);
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_miso", 32'(MISO), 32'd0);
                chk("rst_mem_re", 32'(mem_re), 32'd0);
                chk("rst_mem_we", 32'(mem_we), 32'd0);
                break;
            end
            j = n - 1 - (F + 2);
            if (n == F + 1) begin
                chk("cmd_err", 32'(cmd_err), 32'(cmd[2:1] == 2'b10));
                if (is_rd) chk("rd_issue", 32'({mem_re, mem_addr}), 32'({1'b1, rd_addr_m}));
                else chk("no_mem_re", 32'(mem_re), 32'd0);
            end
            if (is_rd && j >= 0 && j < n_words * DW) begin
                got = {got[DW-2:0], MISO};
                if (j % DW == DW - 1) begin
                    chk("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                    if (exp_rd.size() != 0) chk("miso_word", 32'(got), 32'(exp_rd.pop_front()));
                end
            end else if (is_rd && j >= n_words * DW) begin
                chk("miso_tail", 32'(MISO), 32'd0);
            end
            if (n <= total) begin
                if (n <= F) begin
                    fr   = {cmd, payload} << (n - 1);
                    MOSI = fr[F-1];
                end else if (cmd == 3'b010) begin
                    w    = bw[2'((n - F - 1) / DW + 1)] << ((n - F - 1) % DW);
                    MOSI = w[DW-1];
                end else begin
                    MOSI = 1'($urandom);
                end
            end else begin
                SS_n = 1'b1;
                MOSI = 1'b0;
            end
        end
        if (rst_at > 0) begin
            SS_n = 1'b1;
            MOSI = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        @(negedge clk);
        chk("miso_idle", 32'(MISO), 32'd0);
    endtask

    task automatic wr_addr_cmd(input logic [AW-1:0] a);
        xfer(3'b000, a, 1, -1, -1);
        wr_addr_m = a;
    endtask

    task automatic wr_data_cmd(input logic [DW-1:0] d);
        exp_wr.push_back({wr_addr_m, d});
        ref_mem[wr_addr_m] = d;
        xfer(3'b001, d, 1, -1, -1);
    endtask

    task automatic rd_addr_cmd(input logic [AW-1:0] a);
        xfer(3'b110, a, 1, -1, -1);
        rd_addr_m = a;
    endtask

    task automatic rd_data_cmd();
        exp_rd.push_back(ref_mem[rd_addr_m]);
        xfer(3'b111, DW'($urandom), 1, -1, -1);
    endtask

    task automatic wr_burst_cmd(input int n);
        for (int k = 0; k < n; k++) begin
            exp_wr.push_back({AW'(wr_addr_m + k), bw[k]});
            ref_mem[AW'(wr_addr_m + k)] = bw[k];
        end
        xfer(3'b010, bw[0], n, -1, -1);
        wr_addr_m = AW'(wr_addr_m + n);
    endtask

    task automatic rd_burst_cmd(input int n, input int n_expect, input int rst_at);
        for (int k = 0; k < n_expect; k++) exp_rd.push_back(ref_mem[AW'(rd_addr_m + k)]);
        xfer(3'b011, DW'($urandom), n, -1, rst_at);
        rd_addr_m = AW'(rd_addr_m + n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        rst_n = 1'b0;
        SS_n  = 1'b1;
        MOSI  = 1'b0;
        preload(8'h10, 8'hAA);
        preload(8'h11, 8'hBB);
        preload(8'h12, 8'hCC);
        preload(8'h13, 8'hDD);
        preload(8'h40, 8'h5A);
        preload(8'h41, 8'hFF);
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({MISO, mem_we, mem_re, cmd_err, mem_addr, mem_wdata}), 32'd0);
        rst_n     = 1'b1;
        wr_addr_m = '0;
        rd_addr_m = '0;
        @(negedge clk);

        wr_addr_cmd(8'h3C);
        wr_data_cmd(8'hA5);
        rd_addr_cmd(8'h3C);
        rd_data_cmd();

        wr_addr_cmd(8'hFE);
        bw[0] = 8'h11;
        bw[1] = 8'h22;
        bw[2] = 8'h33;
        wr_burst_cmd(3);
        wr_data_cmd(8'h77);

        rd_addr_cmd(8'h10);
        rd_burst_cmd(3, 3, -1);
        rd_data_cmd();

        xfer(3'b100, 8'hFF, 1, -1, -1);
        xfer(3'b101, 8'h00, 1, -1, -1);
        wr_data_cmd(8'h5C);
        rd_data_cmd();

        xfer(3'b001, 8'hE7, 1, 3 + 6, -1);
        wr_data_cmd(8'hE7);

        rd_addr_cmd(8'h40);
        rd_burst_cmd(3, 1, F + 3 + DW);
        wr_addr_m = '0;
        rd_addr_m = '0;
        rd_data_cmd();
        wr_data_cmd(8'h6B);
        rd_data_cmd();

        for (int i = 0; i < 4; i++) begin
            ra = AW'($urandom_range(8'h80, 8'hEF));
            rd = DW'($urandom);
            wr_addr_cmd(ra);
            wr_data_cmd(rd);
            rd_addr_cmd(ra);
            rd_data_cmd();
        end

        repeat (3) @(negedge clk);
        chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
